adder_pipe_cla: RTL
===================

ADDER_PIPE_CLA -- requirements
Module: adder_pipe_cla

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and sum width; legal values are multiples of BLOCK.
REQ-002 The block SHALL have parameter BLOCK, default 16: carry-lookahead group width, one group per pipeline stage.
REQ-003 The block SHALL derive STAGES = WIDTH/BLOCK, which is also the latency in cycles.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operands present this cycle.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry in; ignored when sub=1.
REQ-011 sub  input  1  0 = A+B+cin; 1 = A-B, computed as A+~B+1.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-015 cout  output  1  carry out of the MSB; for sub=1 this is the no-borrow flag.
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Stage k (k = 0..STAGES-1) SHALL add bits [k*BLOCK +: BLOCK] using group P/G lookahead, taking the carry registered from stage k-1 (stage 0 takes cin, or 1 when sub=1).
REQ-018 Operand slices not yet consumed SHALL travel skewed through the pipeline; completed sum slices SHALL be carried forward so that all of sum appears aligned at the output.
REQ-019 Global advance: adv = !out_valid || out_ready; every stage register, including the valid bits, SHALL load only when adv=1.
REQ-020 in_ready SHALL equal adv combinationally; a transfer occurs when in_valid && in_ready.
REQ-021 A stage with valid=0 is a bubble; bubbles SHALL propagate and not be compressed.
REQ-022 With out_ready held at 1, the result of an input transfer in cycle t SHALL be presented with out_valid=1 in cycle t+STAGES.
REQ-023 Throughput SHALL be one result per cycle when out_ready=1.
REQ-024 While out_valid=1 and out_ready=0, sum, cout, ovf and out_valid SHALL hold stable and no input SHALL be accepted.
REQ-025 ovf SHALL equal (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff = sub ? ~b : b; the needed sign bits SHALL be carried in the pipeline.
REQ-026 Results SHALL leave the block in acceptance order, with no loss or duplication under arbitrary in_valid/out_ready patterns.

Reset
REQ-027 While rst=1, all stage valid bits and out_valid SHALL be 0, and sum, cout and ovf SHALL be 0.
REQ-028 An rst asserted mid-operation SHALL discard all in-flight results.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-030 A shared package adder_pkg SHALL hold the WIDTH/BLOCK defaults, the STAGES derivation function, and the stage-payload struct (valid, carry, sum bits, remaining operand bits, sign bits).
REQ-031 One sub-module, cla_block, SHALL be used: a combinational BLOCK-bit carry-lookahead adder with inputs a, b, c0 and outputs s, px, gx, instantiated once per stage.
REQ-032 No other sub-modules SHALL be used; the pipeline registers SHALL live in adder_pipe_cla.

Verification (WIDTH=32, BLOCK=16, latency 2)
REQ-033 a=0xFFFF_FFFF, b=0x0000_0001, cin=0, sub=0 -> after 2 cycles sum=0x0000_0000, cout=1, ovf=0 (carry crosses the stage boundary).
REQ-034 a=0x7FFF_FFFF, b=1, sub=0 -> sum=0x8000_0000, cout=0, ovf=1; a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1.
REQ-035 Back-to-back stream of 100 random transfers with out_ready=1 -> 100 results in consecutive cycles, each matching the reference model, in order.
REQ-036 Hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, outputs stable; release -> all results in order, none lost or duplicated.
REQ-037 Assert rst with 2 operations in flight -> out_valid=0 immediately; none of those results ever appear; a new operation after reset returns its correct sum.
REQ-038 Random in_valid and out_ready (50% each), 10k operations with sub and cin randomised -> scoreboard matches sum, cout and ovf exactly.

Source files
------------

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined carry-lookahead adder.
//   ADDER_WIDTH  default operand / sum width
//   ADDER_BLOCK  default lookahead group width (one group per pipeline stage)
//   calc_stages  number of pipeline stages (and cycles of latency)
//   stage_t      payload held in each pipeline register
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int ADDER_BLOCK = 16;

    function automatic int calc_stages(input int width, input int block);
        return width / block;
    endfunction

    // One pipeline register's worth of state. Sum slices fill in from the
    // bottom as the operation moves down the pipe; a_rem/b_rem hold the
    // operand slices still to be added, shifted so the next stage always
    // finds its slice in the low BLOCK bits. The two sign bits are kept
    // because the operand MSBs are shifted out long before the last stage
    // needs them for the overflow flag.
    typedef struct packed {
        logic                   valid;
        logic                   carry;
        logic [ADDER_WIDTH-1:0] sum;
        logic [ADDER_WIDTH-1:0] a_rem;
        logic [ADDER_WIDTH-1:0] b_rem;
        logic                   a_msb;
        logic                   b_msb;
    } stage_t;

endpackage

// File: rtl/cla_block.sv
// ---------------------------------------------------------------------------
// cla_block
// Purely combinational BLOCK-bit carry-lookahead adder.
//   a, b  input   operands
//   c0    input   carry into bit 0
//   s     output  sum bits
//   px    output  group propagate (all bits propagate)
//   gx    output  group generate (block produces a carry on its own)
// The carry out of the group is gx | (px & c0); the caller forms it so the
// group signals stay visible for wider lookahead if ever needed.
// ---------------------------------------------------------------------------
module cla_block #(
    parameter int BLOCK = 16
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c0,
    output logic [BLOCK-1:0] s,
    output logic             px,
    output logic             gx
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] gpre;
    logic [BLOCK-1:0] ppre;
    logic [BLOCK-1:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        gpre = '0;
        ppre = '0;
        c    = '0;

        // Prefix group generate/propagate over bits [i:0]; every carry is
        // then a direct function of its prefix pair and c0.
        gpre[0] = g[0];
        ppre[0] = p[0];
        for (int i = 1; i < BLOCK; i++) begin
            gpre[i] = g[i] | (p[i] & gpre[i-1]);
            ppre[i] = p[i] & ppre[i-1];
        end

        c[0] = c0;
        for (int i = 1; i < BLOCK; i++) begin
            c[i] = gpre[i-1] | (ppre[i-1] & c0);
        end

        s  = p ^ c;
        px = ppre[BLOCK-1];
        gx = gpre[BLOCK-1];
    end

endmodule

// File: rtl/adder_pipe_cla.sv
// ---------------------------------------------------------------------------
// adder_pipe_cla
// Pipelined adder/subtractor: one BLOCK-bit lookahead group per stage, the
// group carry registered between stages, latency STAGES = WIDTH/BLOCK.
//   clk        input   clock, rising edge
//   rst        input   asynchronous active-high reset
//   in_valid   input   operands present
//   in_ready   output  operands accepted this cycle
//   a, b       input   operands (WIDTH)
//   cin        input   carry in (ignored when sub=1)
//   sub        input   0: a+b+cin, 1: a-b as a+~b+1
//   out_valid  output  result present
//   out_ready  input   consumer takes result
//   sum        output  result modulo 2^WIDTH
//   cout       output  carry out of MSB (no-borrow flag when subtracting)
//   ovf        output  two's-complement overflow
// WIDTH must equal adder_pkg::ADDER_WIDTH because the stage payload struct
// is sized there; BLOCK may be any divisor of WIDTH.
//
// Handshake: a transfer happens on a rising edge where valid && ready on the
// same side. The whole pipe advances as one (adv = !out_valid || out_ready);
// in_ready is adv, so an input is taken exactly when every stage moves and
// bubbles keep their position. A presented result holds until taken.
// ---------------------------------------------------------------------------
module adder_pipe_cla
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int BLOCK = ADDER_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, BLOCK);

    stage_t           pipe_q [STAGES];
    stage_t           pipe_d [STAGES];
    logic             adv;
    logic [WIDTH-1:0] b_eff;

    logic [BLOCK-1:0] st_a  [STAGES];
    logic [BLOCK-1:0] st_b  [STAGES];
    logic [BLOCK-1:0] st_s  [STAGES];
    logic             st_c  [STAGES];
    logic             st_px [STAGES];
    logic             st_gx [STAGES];

    // Subtraction is a+~b+1: invert b here and force the stage-0 carry.
    assign b_eff = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign st_a[k] = a[BLOCK-1:0];
            assign st_b[k] = b_eff[BLOCK-1:0];
            assign st_c[k] = sub | cin;
        end else begin : g_rest
            assign st_a[k] = pipe_q[k-1].a_rem[BLOCK-1:0];
            assign st_b[k] = pipe_q[k-1].b_rem[BLOCK-1:0];
            assign st_c[k] = pipe_q[k-1].carry;
        end

        cla_block #(
            .BLOCK (BLOCK)
        ) u_cla (
            .a  (st_a[k]),
            .b  (st_b[k]),
            .c0 (st_c[k]),
            .s  (st_s[k]),
            .px (st_px[k]),
            .gx (st_gx[k])
        );
    end

    always_comb begin
        // Stage 0 captures the fresh operands.
        pipe_d[0]       = '0;
        pipe_d[0].valid = in_valid;
        pipe_d[0].a_rem = a >> BLOCK;
        pipe_d[0].b_rem = b_eff >> BLOCK;
        pipe_d[0].a_msb = a[WIDTH-1];
        pipe_d[0].b_msb = b_eff[WIDTH-1];
        pipe_d[0].sum[BLOCK-1:0] = st_s[0];
        pipe_d[0].carry = st_gx[0] | (st_px[0] & st_c[0]);

        // Later stages inherit everything and add their own slice.
        for (int k = 1; k < STAGES; k++) begin
            pipe_d[k]       = pipe_q[k-1];
            pipe_d[k].a_rem = pipe_q[k-1].a_rem >> BLOCK;
            pipe_d[k].b_rem = pipe_q[k-1].b_rem >> BLOCK;
            pipe_d[k].sum[k*BLOCK +: BLOCK] = st_s[k];
            pipe_d[k].carry = st_gx[k] | (st_px[k] & st_c[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    assign adv       = !pipe_q[STAGES-1].valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = pipe_q[STAGES-1].valid;
    assign sum       = pipe_q[STAGES-1].sum;
    assign cout      = pipe_q[STAGES-1].carry;
    // Overflow: operands of equal sign produced a result of the other sign.
    assign ovf       = (pipe_q[STAGES-1].a_msb == pipe_q[STAGES-1].b_msb) &&
                       (pipe_q[STAGES-1].sum[WIDTH-1] != pipe_q[STAGES-1].a_msb);

endmodule
